// File: rtl/game_pkg.sv
// Shared game state codes and sizing helpers, imported by the sequencer and the
// display overlay logic.
package game_pkg;

    localparam int STATE_W        = 3;
    localparam int TAIL_W_DEFAULT = 6;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_NEWGAME = 3'd1,
        ST_COUNT   = 3'd2,
        ST_PLAY    = 3'd3,
        ST_PAUSE   = 3'd4,
        ST_OVER    = 3'd5,
        ST_WON     = 3'd6
    } state_t;

    // Counter width for a modulus of n; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/frame_divider.sv
// Modulo-N frame_tick counter with synchronous clear (load) and freeze; wrap is
// asserted combinationally on the tick that completes N frames.
module frame_divider
    import game_pkg::*;
#(
    parameter int N = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic load,
    input  logic freeze,
    output logic wrap
);

    localparam int           W    = cnt_w(N);
    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] cnt;

    assign wrap = tick && !freeze && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset || load) begin
            cnt <= '0;
        end else if (tick && !freeze) begin
            cnt <= wrap ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/game_seq_ctrl.sv
// Game life-cycle sequencer: title, reset pulse, countdown, play, pause, end.
// Optional PLAY<->PAUSE toggling on the start button is built with GAME_PAUSE_EN.
module game_seq_ctrl
    import game_pkg::*;
#(
    parameter int SPEED_FRAMES = 8,
    parameter int COUNT_FRAMES = 60,
    parameter int RST_CYCLES   = 4,
    parameter int TAIL_W       = TAIL_W_DEFAULT
) (
    input  logic               vga_clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               start_btn,
    input  logic               game_over_in,
    input  logic               game_won_in,
    input  logic [TAIL_W-1:0]  tail_count,
    output logic               game_rst,
    output logic               upd_en,
    output logic [STATE_W-1:0] state,
    output logic [1:0]         cd_digit,
    output logic [TAIL_W-1:0]  score,
    output logic [TAIL_W-1:0]  high_score
);

    localparam int RW = cnt_w(RST_CYCLES);

    state_t         st, nxt;
    logic           sync0, sync1, sync1_d, start_p;
    logic [RW-1:0]  rst_cnt;
    logic [1:0]     cd_nxt;
    logic           upd_nxt, latch, end_game;
    logic           cd_wrap, spd_wrap, cd_load, spd_load, rst_load;
    logic           cd_frz, spd_frz;

    // Button: two-flop synchronizer, then a registered rising-edge pulse.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            sync0   <= 1'b0;
            sync1   <= 1'b0;
            sync1_d <= 1'b0;
            start_p <= 1'b0;
        end else begin
            sync0   <= start_btn;
            sync1   <= sync0;
            sync1_d <= sync1;
            start_p <= sync1 & ~sync1_d;
        end
    end

    assign end_game = game_won_in || game_over_in;

    always_comb begin
        nxt     = st;
        cd_nxt  = cd_digit;
        upd_nxt = 1'b0;
        latch   = 1'b0;
        case (st)
            ST_IDLE: begin
                cd_nxt = 2'd0;
                if (start_p) nxt = ST_NEWGAME;
            end
            ST_NEWGAME: begin
                if (rst_cnt == '0) begin
                    nxt    = ST_COUNT;
                    cd_nxt = 2'd3;
                end
            end
            ST_COUNT: begin
                if (cd_wrap) begin
                    if (cd_digit == 2'd1) begin
                        nxt    = ST_PLAY;
                        cd_nxt = 2'd0;
                    end else begin
                        cd_nxt = cd_digit - 2'd1;
                    end
                end
            end
            ST_PLAY: begin
                // End of game outranks both the advance pulse and a pause request.
                if (end_game) begin
                    nxt   = game_won_in ? ST_WON : ST_OVER;
                    latch = 1'b1;
                end else begin
                    upd_nxt = spd_wrap;
`ifdef GAME_PAUSE_EN
                    if (start_p) begin
                        nxt   = ST_PAUSE;
                        latch = 1'b1;
                    end
`endif
                end
            end
`ifdef GAME_PAUSE_EN
            ST_PAUSE: begin
                if (start_p) nxt = ST_PLAY;
            end
`endif
            ST_OVER, ST_WON: begin
                if (start_p) nxt = ST_NEWGAME;
            end
            default: begin
                nxt    = ST_IDLE;
                cd_nxt = 2'd0;
            end
        endcase
    end

    assign rst_load = (nxt == ST_NEWGAME) && (st != ST_NEWGAME);
    assign cd_load  = (nxt == ST_COUNT) && (st != ST_COUNT);
    assign spd_load = (st == ST_COUNT) && (nxt == ST_PLAY);
    assign cd_frz   = (st != ST_COUNT);
    assign spd_frz  = (st != ST_PLAY);

    frame_divider #(.N(COUNT_FRAMES)) u_cd_div (
        .clk    (vga_clk),
        .reset  (reset),
        .tick   (frame_tick),
        .load   (cd_load),
        .freeze (cd_frz),
        .wrap   (cd_wrap)
    );

    frame_divider #(.N(SPEED_FRAMES)) u_spd_div (
        .clk    (vga_clk),
        .reset  (reset),
        .tick   (frame_tick),
        .load   (spd_load),
        .freeze (spd_frz),
        .wrap   (spd_wrap)
    );

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            st         <= ST_IDLE;
            game_rst   <= 1'b1;
            upd_en     <= 1'b0;
            cd_digit   <= 2'd0;
            score      <= '0;
            high_score <= '0;
            rst_cnt    <= '0;
        end else begin
            st       <= nxt;
            game_rst <= (nxt == ST_IDLE) || (nxt == ST_NEWGAME);
            upd_en   <= upd_nxt;
            cd_digit <= cd_nxt;
            if (latch) begin
                score <= tail_count;
                if (tail_count > high_score) high_score <= tail_count;
            end
            // Loaded on entry so NEWGAME lasts exactly RST_CYCLES cycles.
            if (rst_load) begin
                rst_cnt <= RW'(RST_CYCLES - 1);
            end else if ((st == ST_NEWGAME) && (rst_cnt != '0)) begin
                rst_cnt <= rst_cnt - RW'(1);
            end
        end
    end

    assign state = st;

endmodule

// File: tb/tb_game_seq_ctrl.sv
// Randomized bench for game_seq_ctrl: a tick-counting reference model queues
// expected observable events, a monitor pops and compares them against the DUT.
module tb_game_seq_ctrl;

    localparam int SPD = 2;
    localparam int CNT = 3;
    localparam int RST = 4;
    localparam int TW  = 6;
`ifdef GAME_PAUSE_EN
    localparam bit PAUSE_ON = 1'b1;
`else
    localparam bit PAUSE_ON = 1'b0;
`endif

    logic          vga_clk = 1'b0;
    logic          reset = 1'b1;
    logic          frame_tick = 1'b0;
    logic          start_btn = 1'b0;
    logic          game_over_in = 1'b0;
    logic          game_won_in = 1'b0;
    logic [TW-1:0] tail_count = '0;
    logic          game_rst, upd_en;
    logic [2:0]    state;
    logic [1:0]    cd_digit;
    logic [TW-1:0] score, high_score;

    game_seq_ctrl #(
        .SPEED_FRAMES(SPD), .COUNT_FRAMES(CNT), .RST_CYCLES(RST), .TAIL_W(TW)
    ) dut (
        .vga_clk(vga_clk), .reset(reset), .frame_tick(frame_tick),
        .start_btn(start_btn), .game_over_in(game_over_in),
        .game_won_in(game_won_in), .tail_count(tail_count),
        .game_rst(game_rst), .upd_en(upd_en), .state(state),
        .cd_digit(cd_digit), .score(score), .high_score(high_score)
    );

    always #5 vga_clk = ~vga_clk;

    typedef struct {
        int cyc; int st; int cd; int sc; int hs; int grst; int upd;
    } ev_t;

    ev_t exp_q[$];
    int  total = 0;
    int  bad   = 0;
    int  cyc   = 0;
    int  tcnt  = 0;

    // Frame tick every 10 cycles.
    initial begin
        forever begin
            @(negedge vga_clk);
            tcnt++;
            frame_tick = (tcnt % 10 == 0);
        end
    end

    // Reference model: phases named by spec codes, timing via elapsed counts.
    int       m_ph = 0, m_cd = 0, m_sc = 0, m_hs = 0, m_upd = 0;
    int       ng_cyc = 0, cd_ticks = 0, play_ticks = 0;
    int       prev_ph, prev_cd;
    bit [3:0] hist = '0;
    bit       sp;

    initial begin
        forever begin
            @(posedge vga_clk);
            cyc++;
            prev_ph = m_ph;
            prev_cd = m_cd;
            m_upd   = 0;
            if (reset) begin
                m_ph = 0; m_sc = 0; m_hs = 0; hist = '0;
            end else begin
                // start_p at this edge reflects the button three edges ago.
                sp   = hist[2] && !hist[3];
                hist = {hist[2:0], start_btn};
                case (m_ph)
                    0: if (sp) begin m_ph = 1; ng_cyc = 0; end
                    1: begin
                        ng_cyc++;
                        if (ng_cyc == RST) begin m_ph = 2; cd_ticks = 0; end
                    end
                    2: if (frame_tick) begin
                        cd_ticks++;
                        if (cd_ticks == 3 * CNT) begin m_ph = 3; play_ticks = 0; end
                    end
                    3: begin
                        if (game_won_in || game_over_in) begin
                            m_ph = game_won_in ? 6 : 5;
                            m_sc = int'(tail_count);
                            if (m_sc > m_hs) m_hs = m_sc;
                        end else begin
                            if (frame_tick) begin
                                play_ticks++;
                                m_upd = (play_ticks % SPD == 0) ? 1 : 0;
                            end
                            if (PAUSE_ON && sp) begin
                                m_ph = 4;
                                m_sc = int'(tail_count);
                                if (m_sc > m_hs) m_hs = m_sc;
                            end
                        end
                    end
                    4: if (sp) m_ph = 3;
                    default: if (sp) begin m_ph = 1; ng_cyc = 0; end
                endcase
            end
            m_cd = (m_ph == 2) ? 3 - cd_ticks / CNT : 0;
            if (m_ph != prev_ph || m_cd != prev_cd || m_upd != 0)
                exp_q.push_back('{cyc, m_ph, m_cd, m_sc, m_hs,
                                  (m_ph <= 1) ? 1 : 0, m_upd});
        end
    end

    // Monitor: any state/digit change or advance pulse is an event to match.
    int  p_st = 0, p_cd = 0;
    ev_t e;
    initial begin
        forever begin
            @(negedge vga_clk);
            if (int'(state) != p_st || int'(cd_digit) != p_cd || upd_en) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_event cyc=%0d st=%0d cd=%0d upd=%0d, want none",
                             cyc, state, cd_digit, upd_en);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || e.st != int'(state) || e.cd != int'(cd_digit) ||
                        e.sc != int'(score) || e.hs != int'(high_score) ||
                        e.grst != int'(game_rst) || e.upd != int'(upd_en)) begin
                        bad++;
                        $display("FAIL event got cyc=%0d st=%0d cd=%0d sc=%0d hs=%0d grst=%0d upd=%0d want cyc=%0d st=%0d cd=%0d sc=%0d hs=%0d grst=%0d upd=%0d",
                                 cyc, state, cd_digit, score, high_score, game_rst, upd_en,
                                 e.cyc, e.st, e.cd, e.sc, e.hs, e.grst, e.upd);
                    end
                end
            end
            p_st = int'(state);
            p_cd = int'(cd_digit);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge vga_clk);
    endtask

    task automatic chk(input string nm, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, got, want);
        end
    endtask

    task automatic press();
        start_btn = 1'b1;
        step($urandom_range(1, 6));
        start_btn = 1'b0;
        step(2);
    endtask

    task automatic wait_st(input int tgt, input int budget, input string nm);
        int k = 0;
        while (int'(state) != tgt && k < budget) begin
            step(1);
            k++;
        end
        chk(nm, int'(state), tgt);
    endtask

    task automatic play_random(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            if (i % 7 == 0) tail_count = TW'($urandom_range(0, (1 << TW) - 1));
            if ($urandom_range(0, 99) == 0) press();
            else step(1);
        end
    endtask

    task automatic end_game(input int kind);
        int k = 0;
        game_over_in = (kind != 1);
        game_won_in  = (kind != 0);
        while (int'(state) < 5 && k < 200) begin
            if (int'(state) == 4) press();
            else step(1);
            k++;
        end
        chk("end_reached", (int'(state) >= 5) ? 1 : 0, 1);
    endtask

    initial begin
        step(3);
        chk("rst_state", int'(state), 0);
        chk("rst_game_rst", int'(game_rst), 1);
        chk("rst_upd_en", int'(upd_en), 0);
        chk("rst_cd", int'(cd_digit), 0);
        chk("rst_score", int'(score), 0);
        chk("rst_high", int'(high_score), 0);
        reset = 1'b0;
        step(200);
        chk("idle_state", int'(state), 0);
        chk("idle_game_rst", int'(game_rst), 1);

        // Game 1: over with 17.
        press();
        wait_st(3, 200, "reach_play1");
        step(100);
        tail_count = TW'(17);
        game_over_in = 1'b1;
        wait_st(5, 10, "over1");
        chk("score1", int'(score), 17);
        chk("high1", int'(high_score), 17);
        game_over_in = 1'b0;
        step(5);

        // Game 2: won with 9, high score keeps 17.
        press();
        wait_st(3, 200, "reach_play2");
        play_random(60);
        tail_count = TW'(9);
        game_won_in = 1'b1;
        wait_st(6, 10, "won2");
        chk("score2", int'(score), 9);
        chk("high2", int'(high_score), 17);
        game_won_in = 1'b0;
        step(5);

        // Game 3: won, over and start_p land on the same edge.
        press();
        wait_st(3, 200, "reach_play3");
        step(13);
        start_btn = 1'b1;
        step(3);
        game_won_in  = 1'b1;
        game_over_in = 1'b1;
        step(1);
        chk("all_same_cycle", int'(state), 6);
        start_btn = 1'b0;
        game_won_in = 1'b0;
        game_over_in = 1'b0;
        step(5);

        for (int g = 0; g < 6; g++) begin
            press();
            play_random($urandom_range(150, 350));
            end_game($urandom_range(0, 2));
            step($urandom_range(3, 10));
            game_won_in  = 1'b0;
            game_over_in = 1'b0;
        end

        // Reset in the middle of play clears the high score.
        press();
        wait_st(3, 200, "reach_play_rst");
        step(30);
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        chk("midreset_state", int'(state), 0);
        chk("midreset_high", int'(high_score), 0);
        step(20);

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL missing_events got=%0d pending want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
